instr_mem_responder: RTL and testbench
======================================

// Module: instr_mem_responder
// PURPOSE
//  Instruction-memory responder: the slave end of the core's fetch interface. Accepts one
//  fetch request (byte address) at a time, returns the 32-bit instruction word after a
//  programmable latency, holds it under back-pressure, flags misaligned/out-of-range fetches.
//  A side-band loader port writes program words before or between fetches.
// PARAMETERS
//  DEPTH        256           number of 32-bit words; word index = addr[31:2]
//  LATENCY      1             cycles from request accept to rsp_valid; legal 1..15
//  ERR_INSTR    32'h00000013  word returned with rsp_err (addi x0,x0,0 = NOP)
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  req_valid  in   1   fetch request present
//  req_ready  out  1   responder can accept a request this cycle
//  req_addr   in   32  fetch byte address (PC)
//  rsp_valid  out  1   rsp_instr/rsp_err valid
//  rsp_ready  in   1   core consumes response this cycle
//  rsp_instr  out  32  fetched instruction word
//  rsp_err    out  1   fetch fault (misaligned or out of range)
//  load_en    in   1   write load_data to word load_addr[31:2] this cycle
//  load_addr  in   32  loader byte address (bits [1:0] ignored)
//  load_data  in   32  loader data
//  busy       out  1   request outstanding (state != IDLE)
// BEHAVIOUR
//  Interface: one clock (clk); reset rst_n is asynchronous and active-low.
//  Reset: state=IDLE, rsp_valid=0, rsp_err=0, rsp_instr=0, busy=0, latency counter=0.
//   Memory array is NOT reset; contents survive reset. Reset mid-request discards it.
//  req_ready = (state==IDLE) && !load_en. Accept = req_valid && req_ready.
//  FSM: IDLE -accept-> (LATENCY==1 ? RESP : WAIT, cnt=LATENCY-2)
//       WAIT: cnt==0 -> RESP, else cnt-=1;  RESP: rsp_ready -> IDLE, else hold.
//  Latency: accept at edge N -> rsp_valid=1 after edge N+LATENCY.
//  Data captured at accept: word read from array in accept cycle into response register;
//   loads after accept do not alter pending rsp_instr.
//  Error: addr[1:0]!=0 or addr[31:2]>=DEPTH -> rsp_err=1, rsp_instr=ERR_INSTR; same latency.
//  While rsp_valid && !rsp_ready: rsp_instr, rsp_err stable; no new accept (one outstanding).
//  rsp_valid=1 only in RESP; deasserts edge after rsp_ready sampled high. Earliest next accept
//   is the cycle after return to IDLE (no same-cycle turnaround).
//  Loader: load_en writes on the edge regardless of FSM state; load_addr[31:2]>=DEPTH ignored.
//   load_en in IDLE blocks accept that cycle (loader priority).
//  req_valid while !req_ready: ignored, no state change; request must be re-presented.
//  Arithmetic: index width = $clog2(DEPTH); range check on full addr[31:2], no wrap.
// STRUCTURE
//  Package rv_mem_pkg: FSM state enum {IDLE,WAIT,RESP}, NOP_INSTR constant, latency-width
//   localparam (4 bits).
//  Sub-module imem_array: DEPTH x 32 storage, sync write port, combinational read port.
//  Top holds FSM, latency counter, address checker, response register.
// TESTING
//  1 Load 0x00500093 at addr 0x0, LATENCY=1; req addr 0x0, rsp_ready=1 -> rsp_valid next
//    cycle, rsp_instr=0x00500093, rsp_err=0, busy back to 0 after handshake.
//  2 LATENCY=4; req addr 0x4 (loaded 0x00A00113) -> rsp_valid exactly 4 edges after accept;
//    req_ready=0 throughout.
//  3 Back-pressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_instr stable; new req_valid
//    ignored; raise rsp_ready -> IDLE, next req accepted.
//  4 req addr 0x6 -> rsp_err=1, rsp_instr=0x00000013; req addr 4*DEPTH -> rsp_err=1.
//  5 Load 0xDEADBEEF to 0x8 one cycle after accept of fetch 0x8 (old 0x11111111)
//    -> rsp_instr=0x11111111; refetch -> 0xDEADBEEF. load_en with req_valid -> req_ready=0.
//  6 Assert rst_n=0 during WAIT -> rsp_valid=0, busy=0 immediately; after release,
//    fetch of 0x0 returns word loaded before reset.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// ----------------------------------------------------------------------------
// rv_mem_pkg
// Shared definitions for the instruction-memory responder slice.
//   state_t      : responder FSM states (IDLE, WAIT, RESP)
//   NOP_INSTR    : instruction word returned on a faulting fetch (addi x0,x0,0)
//   LAT_W        : width of the latency down-counter (covers LATENCY 1..15)
//   fetch_fault  : misaligned / out-of-range test for a fetch byte address
// ----------------------------------------------------------------------------
package rv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int LAT_W = 4;

  // The range check uses the whole word index addr[31:2], so large addresses
  // never alias back into the array.
  function automatic logic fetch_fault(input logic [31:0] addr,
                                       input logic [31:0] depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/instr_mem_responder_if.sv
// ----------------------------------------------------------------------------
// instr_mem_responder_if
// Fetch channel between a core (master) and the instruction memory (slave).
//   req_valid / req_ready / req_addr       : request handshake, byte address
//   rsp_valid / rsp_ready / rsp_instr /
//   rsp_err                                : response handshake, word + fault
// ----------------------------------------------------------------------------
interface instr_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_err
  );

endinterface

// File: rtl/imem_array.sv
// ----------------------------------------------------------------------------
// imem_array
// DEPTH x 32-bit program storage. The contents are deliberately not reset so
// a program loaded before a reset is still there afterwards.
//   clk      in  : write clock
//   wr_en    in  : write wr_data to word wr_idx on the rising edge
//   wr_idx   in  : write word index
//   wr_data  in  : write data
//   rd_idx   in  : read word index
//   rd_data  out : combinational read data
// ----------------------------------------------------------------------------
module imem_array #(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [DEPTH];

  // Single synchronous write port; callers guarantee wr_idx < DEPTH.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Read is combinational so the word can be captured in the accept cycle.
  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/instr_mem_responder.sv
// ----------------------------------------------------------------------------
// instr_mem_responder
// Slave end of the core's fetch interface. Accepts one request at a time,
// captures the addressed word (or ERR_INSTR on a fault) at accept, and
// presents it LATENCY cycles later, holding it until the core takes it.
// A side-band loader writes program words at any time.
//   clk        in   : clock, all state on the rising edge
//   rst_n      in   : asynchronous active-low reset
//   fetch      slave: request/response handshake (instr_mem_responder_if)
//   load_en    in   : write load_data to word load_addr[31:2] this cycle
//   load_addr  in   : loader byte address, bits [1:0] ignored
//   load_data  in   : loader data
//   busy       out  : a request is outstanding (FSM not in IDLE)
// LATENCY must lie in 1..15 (fits the 4-bit latency counter).
// ----------------------------------------------------------------------------
module instr_mem_responder
  import rv_mem_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] ERR_INSTR = NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_mem_responder_if.slave  fetch,
  input  logic                  load_en,
  input  logic [31:0]           load_addr,
  input  logic [31:0]           load_data,
  output logic                  busy
);

  localparam int          IDX_W   = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  state_t           state;
  logic [LAT_W-1:0] cnt;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [31:0]      rsp_instr_q;

  logic             accept;
  logic             req_fault;
  logic             load_in_range;
  logic             wr_en;
  logic [31:0]      rd_data;
  logic             load_lsb_unused;

  assign load_lsb_unused = ^load_addr[1:0];

  // Loads beyond the array are dropped rather than wrapped into it.
  assign load_in_range = ({2'b00, load_addr[31:2]} < DEPTH_U);
  assign wr_en         = load_en && load_in_range;

  imem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (load_addr[IDX_W+1:2]),
    .wr_data (load_data),
    .rd_idx  (fetch.req_addr[IDX_W+1:2]),
    .rd_data (rd_data)
  );

  // The loader has priority: a load in IDLE holds off acceptance, which also
  // means a fetch read never races a write to the array in the same cycle.
  assign fetch.req_ready = (state == IDLE) && !load_en;
  assign accept          = fetch.req_valid && fetch.req_ready;
  assign req_fault       = fetch_fault(fetch.req_addr, DEPTH_U);

  // FSM with registered response. The word is sampled at accept, so later
  // loads to the same address cannot change a response already in flight.
  // cnt is preloaded with LATENCY-2 so that WAIT lasts LATENCY-1 cycles and
  // rsp_valid rises exactly LATENCY cycles after the request cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_instr_q <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_instr_q <= req_fault ? ERR_INSTR : rd_data;
            rsp_err_q   <= req_fault;
            busy        <= 1'b1;
            if (LATENCY == 1) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= LAT_W'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (fetch.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            busy        <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  assign fetch.rsp_valid = rsp_valid_q;
  assign fetch.rsp_err   = rsp_err_q;
  assign fetch.rsp_instr = rsp_instr_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_instr_mem_responder
// Drives two responders (LATENCY 1 and LATENCY 4) sharing clock and reset.
// Expected words come from a per-instance array model of the program memory,
// expected faults and latency from plain address arithmetic.
// ----------------------------------------------------------------------------
module tb_instr_mem_responder;

  localparam int DEPTH = 256;

  int lat_cfg [2] = '{1, 4};

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  instr_mem_responder_if ifc0 ();
  instr_mem_responder_if ifc1 ();

  logic        req_valid [2];
  logic [31:0] req_addr  [2];
  logic        rsp_ready [2];
  logic        load_en   [2];
  logic [31:0] load_addr [2];
  logic [31:0] load_data [2];
  logic        busy      [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_instr [2];
  logic        rsp_err   [2];

  assign ifc0.req_valid = req_valid[0];
  assign ifc0.req_addr  = req_addr[0];
  assign ifc0.rsp_ready = rsp_ready[0];
  assign ifc1.req_valid = req_valid[1];
  assign ifc1.req_addr  = req_addr[1];
  assign ifc1.rsp_ready = rsp_ready[1];

  assign req_ready[0] = ifc0.req_ready;
  assign rsp_valid[0] = ifc0.rsp_valid;
  assign rsp_instr[0] = ifc0.rsp_instr;
  assign rsp_err[0]   = ifc0.rsp_err;
  assign req_ready[1] = ifc1.req_ready;
  assign rsp_valid[1] = ifc1.rsp_valid;
  assign rsp_instr[1] = ifc1.rsp_instr;
  assign rsp_err[1]   = ifc1.rsp_err;

  instr_mem_responder #(
    .DEPTH     (DEPTH),
    .LATENCY   (1),
    .ERR_INSTR (32'h0000_0013)
  ) dut_l1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch     (ifc0.slave),
    .load_en   (load_en[0]),
    .load_addr (load_addr[0]),
    .load_data (load_data[0]),
    .busy      (busy[0])
  );

  instr_mem_responder #(
    .DEPTH     (DEPTH),
    .LATENCY   (4),
    .ERR_INSTR (32'h0000_0013)
  ) dut_l4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch     (ifc1.slave),
    .load_en   (load_en[1]),
    .load_addr (load_addr[1]),
    .load_data (load_data[1]),
    .busy      (busy[1])
  );

  // Behavioural memory model, one per instance.
  logic [31:0] model_mem [2][DEPTH];

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_fault(input logic [31:0] addr);
    return (addr % 4 != 0) || (addr / 4 >= DEPTH);
  endfunction

  function automatic logic [31:0] expected_word(input int sel, input logic [31:0] addr);
    if (is_fault(addr)) return 32'h0000_0013;
    return model_mem[sel][addr / 4];
  endfunction

  task automatic model_load(input int sel, input logic [31:0] addr, input logic [31:0] data);
    if (addr / 4 < DEPTH) model_mem[sel][addr / 4] = data;
  endtask

  // One loader write, applied on a single rising edge.
  task automatic loadWord(input int sel, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    load_en[sel]   = 1'b1;
    load_addr[sel] = addr;
    load_data[sel] = data;
    @(posedge clk);
    #1;
    load_en[sel] = 1'b0;
    model_load(sel, addr, data);
  endtask

  // One fetch transaction: request, measure latency, optionally load the same
  // address right after accept, hold the response for 'stall' cycles while a
  // spurious request is presented, then complete the handshake.
  task automatic applyStimulus(input int sel, input logic [31:0] addr, input int stall,
                               input bit do_load, input logic [31:0] load_val,
                               input string tag);
    logic [31:0] exp_instr;
    logic        exp_err;
    int          lat;
    @(negedge clk);
    req_valid[sel] = 1'b1;
    req_addr[sel]  = addr;
    rsp_ready[sel] = 1'b0;
    checkOutput({tag, "/req_ready_idle"}, 32'(req_ready[sel]), 32'd1);
    exp_instr = expected_word(sel, addr);
    exp_err   = is_fault(addr);
    @(posedge clk);
    #1;
    req_valid[sel] = 1'b0;
    if (do_load) begin
      load_en[sel]   = 1'b1;
      load_addr[sel] = addr;
      load_data[sel] = load_val;
      model_load(sel, addr, load_val);
    end
    lat = 1;
    while (!rsp_valid[sel] && lat < 40) begin
      checkOutput($sformatf("%s/req_ready_wait%0d", tag, lat), 32'(req_ready[sel]), 32'd0);
      @(posedge clk);
      #1;
      load_en[sel] = 1'b0;
      lat++;
    end
    if (load_en[sel]) begin
      @(posedge clk);
      #1;
      load_en[sel] = 1'b0;
    end
    checkOutput({tag, "/latency"}, 32'(lat), 32'(lat_cfg[sel]));
    checkOutput({tag, "/instr"}, rsp_instr[sel], exp_instr);
    checkOutput({tag, "/err"}, 32'(rsp_err[sel]), 32'(exp_err));
    checkOutput({tag, "/busy_resp"}, 32'(busy[sel]), 32'd1);
    for (int i = 0; i < stall; i++) begin
      req_valid[sel] = 1'b1;
      req_addr[sel]  = addr ^ 32'h4;
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s/hold_valid%0d", tag, i), 32'(rsp_valid[sel]), 32'd1);
      checkOutput($sformatf("%s/hold_instr%0d", tag, i), rsp_instr[sel], exp_instr);
      checkOutput($sformatf("%s/hold_err%0d", tag, i), 32'(rsp_err[sel]), 32'(exp_err));
      checkOutput($sformatf("%s/hold_ready%0d", tag, i), 32'(req_ready[sel]), 32'd0);
    end
    req_valid[sel] = 1'b0;
    rsp_ready[sel] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[sel] = 1'b0;
    checkOutput({tag, "/valid_done"}, 32'(rsp_valid[sel]), 32'd0);
    checkOutput({tag, "/busy_done"}, 32'(busy[sel]), 32'd0);
    checkOutput({tag, "/ready_done"}, 32'(req_ready[sel]), 32'd1);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0;
      req_addr[s]  = '0;
      rsp_ready[s] = 1'b0;
      load_en[s]   = 1'b0;
      load_addr[s] = '0;
      load_data[s] = '0;
    end
    rst_n = 1'b0;
    #12;
    for (int s = 0; s < 2; s++) begin
      checkOutput($sformatf("reset%0d/valid", s), 32'(rsp_valid[s]), 32'd0);
      checkOutput($sformatf("reset%0d/busy", s), 32'(busy[s]), 32'd0);
      checkOutput($sformatf("reset%0d/instr", s), rsp_instr[s], 32'd0);
      checkOutput($sformatf("reset%0d/err", s), 32'(rsp_err[s]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Fill both memories so every in-range fetch has a defined model value.
    for (int i = 0; i < DEPTH; i++) begin
      loadWord(0, 32'(4 * i), $urandom);
      loadWord(1, 32'(4 * i), $urandom);
    end

    // Basic LATENCY=1 fetch.
    loadWord(0, 32'h0, 32'h0050_0093);
    applyStimulus(0, 32'h0, 0, 1'b0, 32'h0, "l1_basic");

    // LATENCY=4 fetch.
    loadWord(1, 32'h4, 32'h00A0_0113);
    applyStimulus(1, 32'h4, 0, 1'b0, 32'h0, "l4_basic");

    // Back-pressure, then an immediate follow-up fetch.
    applyStimulus(1, 32'h4, 5, 1'b0, 32'h0, "l4_stall");
    applyStimulus(1, 32'hC, 0, 1'b0, 32'h0, "l4_next");
    applyStimulus(0, 32'h4, 5, 1'b0, 32'h0, "l1_stall");

    // Faulting fetches.
    applyStimulus(0, 32'h6, 0, 1'b0, 32'h0, "l1_misalign");
    applyStimulus(0, 32'(4 * DEPTH), 0, 1'b0, 32'h0, "l1_oor");
    applyStimulus(1, 32'h6, 2, 1'b0, 32'h0, "l4_misalign");
    applyStimulus(1, 32'hFFFF_FFFC, 0, 1'b0, 32'h0, "l4_oor_high");

    // Out-of-range load must not alias into the array.
    loadWord(0, 32'(4 * DEPTH + 8), 32'hBAD0_BAD0);
    applyStimulus(0, 32'h8, 0, 1'b0, 32'h0, "l1_oor_load");

    // Load after accept does not disturb the pending response.
    loadWord(1, 32'h8, 32'h1111_1111);
    applyStimulus(1, 32'h8, 0, 1'b1, 32'hDEAD_BEEF, "l4_load_after");
    applyStimulus(1, 32'h8, 0, 1'b0, 32'h0, "l4_refetch");

    // Load and request together: loader wins, request is dropped.
    @(negedge clk);
    load_en[0]   = 1'b1;
    load_addr[0] = 32'h10;
    load_data[0] = 32'hCAFE_F00D;
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h10;
    #1;
    checkOutput("load_block/req_ready", 32'(req_ready[0]), 32'd0);
    @(posedge clk);
    #1;
    load_en[0]   = 1'b0;
    req_valid[0] = 1'b0;
    model_load(0, 32'h10, 32'hCAFE_F00D);
    checkOutput("load_block/busy", 32'(busy[0]), 32'd0);
    checkOutput("load_block/valid", 32'(rsp_valid[0]), 32'd0);
    applyStimulus(0, 32'h10, 0, 1'b0, 32'h0, "l1_after_load");

    // Reset in the middle of a LATENCY=4 wait.
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h0;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_mid/busy_before", 32'(busy[1]), 32'd1);
    checkOutput("rst_mid/valid_before", 32'(rsp_valid[1]), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid/valid", 32'(rsp_valid[1]), 32'd0);
    checkOutput("rst_mid/busy", 32'(busy[1]), 32'd0);
    checkOutput("rst_mid/instr", rsp_instr[1], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 32'h0, 0, 1'b0, 32'h0, "l4_after_reset");
    applyStimulus(0, 32'h0, 0, 1'b0, 32'h0, "l1_after_reset");

    // Randomized mix of loads and fetches on both instances.
    for (int n = 0; n < 40; n++) begin
      int          sel;
      int          kind;
      logic [31:0] addr;
      sel  = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      if (kind < 3) begin
        addr = 32'($urandom_range(0, 4 * DEPTH + 63));
        loadWord(sel, addr, $urandom);
      end else begin
        if (kind == 3)      addr = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
        else if (kind == 4) addr = 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1000));
        else                addr = 32'(4 * $urandom_range(0, DEPTH - 1));
        applyStimulus(sel, addr, int'($urandom_range(0, 3)), 1'b0, 32'h0,
                      $sformatf("rand%0d", n));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
